dr_ald_pipe: RTL and testbench

Dynamic-range approximate logarithmic divider (DR-ALD), the inverse-direction companion of the DR-ALM multiplier core. It computes a signed quotient a/b by Mitchell subtraction in the log domain. It uses the same LOD and truncate-and-append-1 fraction scheme as the multiplier, followed by a borrow-aware antilog shift. It is a 3-stage elastic pipeline with valid/ready handshakes on both sides, and it sits beside the multiplier in the approximate-arithmetic datapath.

---
 rtl/dr_ald_pipe.sv | 197 +++++++++++++++++++
 tb/tb_dr_ald_pipe.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dr_ald_pipe.sv
// Approximate signed divider: Mitchell log-domain subtraction with truncated
// fractions, a borrow-aware antilog shift, and a 3-stage elastic pipeline.
module dr_ald_pipe #(
   parameter int WIDTH      = 16,
   parameter int KEEP_WIDTH = 7,
   parameter int FRAC_BITS  = 8,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic [WIDTH-1:0]             i_a,
   input  logic [WIDTH-1:0]             i_b,
   input  logic [TAG_WIDTH-1:0]         i_tag,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [WIDTH+FRAC_BITS-1:0]   o_q,
   output logic [TAG_WIDTH-1:0]         o_tag,
   output logic                         o_dbz,
   output logic                         o_sat
);

   localparam int KW = $clog2(WIDTH);
   localparam int QW = WIDTH + FRAC_BITS;
   localparam int MW = QW + KEEP_WIDTH;
   localparam int SW = 16;
   localparam logic [MW-1:0] MAX_M = {{(MW-QW+1){1'b0}}, {(QW-1){1'b1}}};
   localparam logic [QW-1:0] MAX_Q = {1'b0, {(QW-1){1'b1}}};

   typedef struct packed {
      logic                 sign;
      logic                 a_neg;
      logic                 za;
      logic                 zb;
      logic [WIDTH-1:0]     ma;
      logic [WIDTH-1:0]     mb;
      logic [KW-1:0]        ka;
      logic [KW-1:0]        kb;
      logic [TAG_WIDTH-1:0] tag;
   } s1_t;

   typedef struct packed {
      logic                 sign;
      logic                 a_neg;
      logic                 za;
      logic                 zb;
      logic [KW+1:0]        fk;
      logic [KEEP_WIDTH:0]  m;
      logic [TAG_WIDTH-1:0] tag;
   } s2_t;

   function automatic logic [KW-1:0] lod(input logic [WIDTH-1:0] v);
      lod = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) lod = KW'(i);
      end
   endfunction

   // Bits just below the leading one, truncated, with a 1 appended.
   function automatic logic [KEEP_WIDTH-1:0] trunc_frac(input logic [WIDTH-1:0] v,
                                                        input logic [KW-1:0] k);
      trunc_frac = {(KEEP_WIDTH-1)'((v << (WIDTH - 1 - int'(k))) >> (WIDTH - KEEP_WIDTH)),
                    1'b1};
   endfunction

   logic                 s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
   s1_t                  s1_q, s1_d;
   s2_t                  s2_q, s2_d;
   logic [QW-1:0]        q_q, q_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   logic                 dbz_q, dbz_d, sat_q, sat_d;
   logic                 s1_load, s2_load, s3_load;

   // Handshake: a transfer happens on a rising edge when valid && ready. A stage
   // loads when it is empty or its content moves on this cycle, so o_ready
   // follows i_ready combinationally through the chain with no bubble.
   always_comb begin
      s3_load = !s3_v_q || i_ready;
      s2_load = !s2_v_q || s3_load;
      s1_load = !s1_v_q || s2_load;
   end

   assign o_ready = s1_load;
   assign o_valid = s3_v_q;
   assign o_q     = q_q;
   assign o_tag   = tag_q;
   assign o_dbz   = dbz_q;
   assign o_sat   = sat_q;

   // S1: signs, exact magnitudes, leading-one positions
   always_comb begin
      logic a_neg, b_neg;
      logic [WIDTH-1:0] ma, mb;
      a_neg   = i_a[WIDTH-1];
      b_neg   = i_b[WIDTH-1];
      ma      = a_neg ? -i_a : i_a;
      mb      = b_neg ? -i_b : i_b;
      s1_v_d  = s1_load ? i_valid : s1_v_q;
      s1_d    = s1_q;
      if (s1_load && i_valid) begin
         s1_d.sign  = a_neg ^ b_neg;
         s1_d.a_neg = a_neg;
         s1_d.za    = (i_a == '0);
         s1_d.zb    = (i_b == '0);
         s1_d.ma    = ma;
         s1_d.mb    = mb;
         s1_d.ka    = lod(ma);
         s1_d.kb    = lod(mb);
         s1_d.tag   = i_tag;
      end
   end

   // S2: log-domain subtraction; a negative fraction difference borrows one
   // from the characteristic, and its low bits are already the wrapped value.
   always_comb begin
      logic [KEEP_WIDTH-1:0] xa, xb;
      logic [KW+1:0]         dk;
      logic [KEEP_WIDTH:0]   dx;
      xa     = trunc_frac(s1_q.ma, s1_q.ka);
      xb     = trunc_frac(s1_q.mb, s1_q.kb);
      dk     = {2'b00, s1_q.ka} - {2'b00, s1_q.kb};
      dx     = {1'b0, xa} - {1'b0, xb};
      s2_v_d = s2_load ? s1_v_q : s2_v_q;
      s2_d   = s2_q;
      if (s2_load && s1_v_q) begin
         s2_d.sign  = s1_q.sign;
         s2_d.a_neg = s1_q.a_neg;
         s2_d.za    = s1_q.za;
         s2_d.zb    = s1_q.zb;
         s2_d.fk    = dk - {{(KW+1){1'b0}}, dx[KEEP_WIDTH]};
         s2_d.m     = {1'b1, dx[KEEP_WIDTH-1:0]};
         s2_d.tag   = s1_q.tag;
      end
   end

   // S3: antilog shift, saturation, sign, zero-operand overrides
   always_comb begin
      logic signed [SW-1:0] sh;
      logic [SW-1:0]        amt;
      logic [MW-1:0]        mw, mag;
      logic [QW-1:0]        qpos;
      logic                 sat_n;
      sh     = SW'($signed(s2_q.fk)) + SW'(FRAC_BITS - KEEP_WIDTH);
      amt    = sh[SW-1] ? -sh : sh;
      mw     = MW'(s2_q.m);
      mag    = sh[SW-1] ? (mw >> amt) : (mw << amt);
      sat_n  = (mag > MAX_M);
      qpos   = QW'(sat_n ? MAX_M : mag);
      s3_v_d = s3_load ? s2_v_q : s3_v_q;
      q_d    = q_q;
      tag_d  = tag_q;
      dbz_d  = dbz_q;
      sat_d  = sat_q;
      if (s3_load && s2_v_q) begin
         tag_d = s2_q.tag;
         if (s2_q.zb) begin
            dbz_d = 1'b1;
            sat_d = !s2_q.za;
            q_d   = s2_q.za ? '0 : (s2_q.a_neg ? -MAX_Q : MAX_Q);
         end else if (s2_q.za) begin
            dbz_d = 1'b0;
            sat_d = 1'b0;
            q_d   = '0;
         end else begin
            dbz_d = 1'b0;
            sat_d = sat_n;
            q_d   = s2_q.sign ? -qpos : qpos;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         s3_v_q <= 1'b0;
         s1_q   <= '0;
         s2_q   <= '0;
         q_q    <= '0;
         tag_q  <= '0;
         dbz_q  <= 1'b0;
         sat_q  <= 1'b0;
      end else begin
         s1_v_q <= s1_v_d;
         s2_v_q <= s2_v_d;
         s3_v_q <= s3_v_d;
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         q_q    <= q_d;
         tag_q  <= tag_d;
         dbz_q  <= dbz_d;
         sat_q  <= sat_d;
      end
   end

endmodule

// File: tb/tb_dr_ald_pipe.sv
// Bench for dr_ald_pipe: log-domain reference model, queue scoreboard,
// randomized operands and backpressure, plus latency and reset scenarios.
module tb_dr_ald_pipe;

   localparam int WIDTH = 16;
   localparam int KEEP  = 7;
   localparam int FRAC  = 8;
   localparam int TW    = 4;
   localparam int QW    = WIDTH + FRAC;
   localparam int EW    = TW + QW + 2;

   logic              i_clk, i_rst, i_valid, i_ready;
   logic              o_ready, o_valid, o_dbz, o_sat;
   logic [WIDTH-1:0]  i_a, i_b;
   logic [TW-1:0]     i_tag, o_tag;
   logic [QW-1:0]     o_q;

   int                n_cmp = 0;
   int                n_err = 0;
   int                rdy_mode = 0;  // 0 high, 1 random, 2 low
   logic [EW-1:0]     exp_q[$];

   int dir_a[14] = '{100, 9, 7, 1, -100, -32768, 32767, 5, -5, 0, 0, -32768, 1, -32768};
   int dir_b[14] = '{10, 7, 9, 32767, 10, 1, -1, 0, 0, 0, 3, -32768, -32768, 0};

   dr_ald_pipe #(.WIDTH(WIDTH), .KEEP_WIDTH(KEEP), .FRAC_BITS(FRAC), .TAG_WIDTH(TW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_a(i_a), .i_b(i_b), .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready),
      .o_q(o_q), .o_tag(o_tag), .o_dbz(o_dbz), .o_sat(o_sat)
   );

   // clock / reset
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic int flog2(input longint v);
      int k;
      k = 0;
      while ((longint'(1) << (k + 1)) <= v) k++;
      return k;
   endfunction

   // Log value in units of 2^-KEEP: characteristic plus truncated mantissa with 1 appended.
   function automatic longint log_val(input longint mag);
      int k;
      longint frac;
      k    = flog2(mag);
      frac = ((mag - (longint'(1) << k)) * (longint'(1) << (KEEP - 1))) >> k;
      return longint'(k) * (longint'(1) << KEEP) + frac * 2 + 1;
   endfunction

   function automatic logic [EW-1:0] model(input logic [TW-1:0] tag,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
      longint sa, sb, d, fk, m, sh, mag, q, maxv;
      logic dbz, sat;
      maxv = (longint'(1) << (QW - 1)) - 1;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      dbz  = 1'b0;
      sat  = 1'b0;
      q    = 0;
      if (sb == 0) begin
         dbz = 1'b1;
         if (sa != 0) begin
            sat = 1'b1;
            q   = (sa < 0) ? -maxv : maxv;
         end
      end else if (sa != 0) begin
         d   = log_val(sa < 0 ? -sa : sa) - log_val(sb < 0 ? -sb : sb);
         fk  = d >>> KEEP;
         m   = (longint'(1) << KEEP) + (d - fk * (longint'(1) << KEEP));
         sh  = fk + FRAC - KEEP;
         mag = (sh >= 0) ? (m << sh) : (m >> (-sh));
         if (mag > maxv) begin
            mag = maxv;
            sat = 1'b1;
         end
         q = ((sa < 0) != (sb < 0)) ? -mag : mag;
      end
      return {tag, QW'(q), dbz, sat};
   endfunction

   function automatic logic [WIDTH-1:0] pick();
      case ($urandom_range(0, 9))
         0: return '0;
         1: return 16'h8000;
         2: return 16'h7fff;
         3: return 16'hffff;
         4: return 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   // driver tasks: called at a falling edge, return at a falling edge
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [TW-1:0] tag);
      int tries;
      tries   = 0;
      i_valid = 1'b1;
      i_a     = a;
      i_b     = b;
      i_tag   = tag;
      forever begin
         #4;
         if (o_ready) begin
            exp_q.push_back(model(tag, a, b));
            @(negedge i_clk);
            return;
         end
         tries++;
         if (tries > 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: o_ready=0 for 200 cycles, required 1");
            i_valid = 1'b0;
            return;
         end
         @(negedge i_clk);
      end
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0;
      repeat (n) @(negedge i_clk);
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      i_valid = 1'b0;
      while (exp_q.size() != 0 && cyc < 1000) begin
         @(negedge i_clk);
         cyc++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(negedge i_clk);
   endtask

   task automatic latency_op(input logic [TW-1:0] tag, input string name);
      int lat;
      send(16'd100, 16'd10, tag);
      i_valid = 1'b0;
      lat = 0;
      forever begin
         #4;
         lat++;
         if (o_valid || lat >= 20) break;
         @(negedge i_clk);
      end
      check(name, lat, 3);
      @(negedge i_clk);
   endtask

   // downstream ready driver
   initial begin
      i_ready = 1'b1;
      forever begin
         @(negedge i_clk);
         #1;
         case (rdy_mode)
            0: i_ready = 1'b1;
            1: i_ready = ($urandom_range(0, 9) < 7);
            default: i_ready = 1'b0;
         endcase
      end
   end

   // scoreboard monitor
   initial begin
      logic [EW-1:0] e, prev_out;
      logic          prev_stall;
      prev_stall = 1'b0;
      prev_out   = '0;
      forever begin
         @(negedge i_clk);
         #4;
         if (i_rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", o_valid, 1);
               check("hold_data", {o_tag, o_q, o_dbz, o_sat}, prev_out);
            end
            if (o_valid && i_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_output: tag %0d q %0d, required no result", o_tag,
                           $signed(o_q));
               end else begin
                  e = exp_q.pop_front();
                  check("tag", o_tag, e[EW-1 -: TW]);
                  check("q", longint'($signed(o_q)), longint'($signed(e[QW+1:2])));
                  check("dbz", o_dbz, e[1]);
                  check("sat", o_sat, e[0]);
               end
            end
            prev_stall = o_valid && !i_ready;
            prev_out   = {o_tag, o_q, o_dbz, o_sat};
         end
      end
   end

   // main sequence
   initial begin
      bit saw_low;
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_a     = '0;
      i_b     = '0;
      i_tag   = '0;
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      #4;
      check("rst_valid", o_valid, 0);
      check("rst_q", o_q, 0);
      check("rst_tag", o_tag, 0);
      check("rst_dbz", o_dbz, 0);
      check("rst_sat", o_sat, 0);
      check("rst_ready", o_ready, 1);
      @(negedge i_clk);

      for (int i = 0; i < 14; i++) send(16'(dir_a[i]), 16'(dir_b[i]), 4'(i));
      drain();

      latency_op(4'd5, "latency");
      drain();

      rdy_mode = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         send(pick(), pick(), 4'($urandom));
      end
      rdy_mode = 0;
      drain();

      saw_low = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(pick(), pick(), 4'(i + 8));
            i_valid = 1'b0;
         end
         begin
            int w;
            w = 0;
            forever begin
               @(negedge i_clk);
               #4;
               w++;
               if (o_valid || w >= 30) break;
            end
            rdy_mode = 2;
            repeat (4) begin
               @(negedge i_clk);
               #4;
               if (!o_ready) saw_low = 1'b1;
            end
            rdy_mode = 0;
         end
      join
      check("bp_ready_fell", saw_low, 1);
      drain();

      rdy_mode = 2;
      @(negedge i_clk);
      send(16'd9, 16'd7, 4'd10);
      send(16'd7, 16'd9, 4'd11);
      send(16'd3, 16'd2, 4'd12);
      i_valid = 1'b0;
      #2;
      check("pre_rst_valid", o_valid, 1);
      i_rst = 1'b1;
      #1;
      check("async_rst_valid", o_valid, 0);
      check("async_rst_q", o_q, 0);
      exp_q.delete();
      @(negedge i_clk);
      i_rst    = 1'b0;
      rdy_mode = 0;
      #4;
      check("post_rst_ready", o_ready, 1);
      @(negedge i_clk);
      latency_op(4'd3, "post_rst_latency");
      drain();

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
